// File: rtl/rl_dmp_dccm_ecc_scrubber.sv
// DCCM ECC scrubber: turns decoder check results into scrub write-backs, saturating error
// counters, a first-error capture record and a fatal-error pulse.
module rl_dmp_dccm_ecc_scrubber #(
    parameter int ADDR_BITS = 17,
    parameter int DATA_BITS = 32,
    parameter int ECC_BITS  = 8,
    parameter int SYND_BITS = 7,
    parameter int CNT_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 ecc_chk_valid,
    input  logic [ADDR_BITS-1:0] ecc_chk_addr,
    input  logic                 ecc_single_err,
    input  logic                 ecc_double_err,
    input  logic                 ecc_addr_err,
    input  logic [SYND_BITS-1:0] ecc_syndrome,
    input  logic [DATA_BITS-1:0] ecc_data_corr,
    input  logic [ECC_BITS-1:0]  ecc_corr,
    input  logic                 scrub_enable,
    input  logic                 dccm_wr_valid,
    input  logic [ADDR_BITS-1:0] dccm_wr_addr,
    output logic                 scrub_req,
    output logic [ADDR_BITS-1:0] scrub_addr,
    output logic [DATA_BITS-1:0] scrub_wdata,
    output logic [ECC_BITS-1:0]  scrub_wecc,
    input  logic                 scrub_ack,
    output logic                 scrub_drop,
    input  logic                 err_clr,
    output logic [CNT_BITS-1:0]  sb_count,
    output logic [CNT_BITS-1:0]  db_count,
    output logic                 cap_valid,
    output logic [1:0]           cap_type,
    output logic [ADDR_BITS-1:0] cap_addr,
    output logic [SYND_BITS-1:0] cap_syndrome,
    output logic                 fatal_err
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t state;

    logic       ev_single;
    logic       ev_double;
    logic       ev_addr;
    logic       ev_db;
    logic [1:0] ev_type;
    logic       store_hits_chk;
    logic       store_hits_scrub;
    logic       cap_load;

    // Severity priority: address error masks double, double masks single.
    always_comb begin
        ev_addr          = ecc_chk_valid & ecc_addr_err;
        ev_double        = ecc_chk_valid & ecc_double_err & ~ecc_addr_err;
        ev_single        = ecc_chk_valid & ecc_single_err & ~ecc_double_err & ~ecc_addr_err;
        ev_db            = ev_addr | ev_double;
        ev_type          = ev_addr   ? 2'b11 :
                           ev_double ? 2'b10 :
                           ev_single ? 2'b01 : 2'b00;
        store_hits_chk   = dccm_wr_valid && (dccm_wr_addr == ecc_chk_addr);
        store_hits_scrub = dccm_wr_valid && (dccm_wr_addr == scrub_addr);
        // A clear in the same cycle frees the capture register for this event.
        cap_load         = (ev_type != 2'b00) &&
                           (err_clr || !cap_valid || (cap_type == 2'b01 && ev_db));
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state       <= IDLE;
            scrub_req   <= 1'b0;
            scrub_addr  <= '0;
            scrub_wdata <= '0;
            scrub_wecc  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A store to the same word already carries fresh data, so skip the scrub.
                    if (ev_single && scrub_enable && !store_hits_chk) begin
                        state       <= REQ;
                        scrub_req   <= 1'b1;
                        scrub_addr  <= ecc_chk_addr;
                        scrub_wdata <= ecc_data_corr;
                        scrub_wecc  <= ecc_corr;
                    end
                end
                REQ: begin
                    if (scrub_ack || store_hits_scrub) begin
                        state     <= IDLE;
                        scrub_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    scrub_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            scrub_drop <= 1'b0;
        end else if (state == REQ && ev_single) begin
            scrub_drop <= 1'b1;
        end else if (err_clr) begin
            scrub_drop <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            sb_count <= '0;
            db_count <= '0;
        end else begin
            if (err_clr) begin
                sb_count <= ev_single ? CNT_BITS'(1) : '0;
            end else if (ev_single && sb_count != '1) begin
                sb_count <= sb_count + 1'b1;
            end
            if (err_clr) begin
                db_count <= ev_db ? CNT_BITS'(1) : '0;
            end else if (ev_db && db_count != '1) begin
                db_count <= db_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            cap_valid    <= 1'b0;
            cap_type     <= 2'b00;
            cap_addr     <= '0;
            cap_syndrome <= '0;
            fatal_err    <= 1'b0;
        end else begin
            fatal_err <= ev_db;
            if (cap_load) begin
                cap_valid    <= 1'b1;
                cap_type     <= ev_type;
                cap_addr     <= ecc_chk_addr;
                cap_syndrome <= ecc_syndrome;
            end else if (err_clr) begin
                cap_valid    <= 1'b0;
                cap_type     <= 2'b00;
                cap_addr     <= '0;
                cap_syndrome <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rl_dmp_dccm_ecc_scrubber.sv
// Scoreboard bench for rl_dmp_dccm_ecc_scrubber: expected scrub writes are queued at
// stimulus time and popped when the arbiter handshake completes.
module tb_rl_dmp_dccm_ecc_scrubber;

    localparam int AB = 17;
    localparam int DB = 32;
    localparam int EB = 8;
    localparam int SB = 7;
    localparam int CB = 8;

    logic          clk = 1'b0;
    logic          rst_a = 1'b1;
    logic          ecc_chk_valid;
    logic [AB-1:0] ecc_chk_addr;
    logic          ecc_single_err;
    logic          ecc_double_err;
    logic          ecc_addr_err;
    logic [SB-1:0] ecc_syndrome;
    logic [DB-1:0] ecc_data_corr;
    logic [EB-1:0] ecc_corr;
    logic          scrub_enable;
    logic          dccm_wr_valid;
    logic [AB-1:0] dccm_wr_addr;
    logic          scrub_req;
    logic [AB-1:0] scrub_addr;
    logic [DB-1:0] scrub_wdata;
    logic [EB-1:0] scrub_wecc;
    logic          scrub_ack;
    logic          scrub_drop;
    logic          err_clr;
    logic [CB-1:0] sb_count;
    logic [CB-1:0] db_count;
    logic          cap_valid;
    logic [1:0]    cap_type;
    logic [AB-1:0] cap_addr;
    logic [SB-1:0] cap_syndrome;
    logic          fatal_err;

    typedef struct packed {
        logic [AB-1:0] a;
        logic [DB-1:0] d;
        logic [EB-1:0] e;
    } scrub_t;

    scrub_t exp_q[$];
    int     errors = 0;
    int     checks = 0;

    rl_dmp_dccm_ecc_scrubber #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .ECC_BITS(EB), .SYND_BITS(SB), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .rst_a(rst_a),
        .ecc_chk_valid(ecc_chk_valid), .ecc_chk_addr(ecc_chk_addr),
        .ecc_single_err(ecc_single_err), .ecc_double_err(ecc_double_err),
        .ecc_addr_err(ecc_addr_err), .ecc_syndrome(ecc_syndrome),
        .ecc_data_corr(ecc_data_corr), .ecc_corr(ecc_corr),
        .scrub_enable(scrub_enable), .dccm_wr_valid(dccm_wr_valid), .dccm_wr_addr(dccm_wr_addr),
        .scrub_req(scrub_req), .scrub_addr(scrub_addr), .scrub_wdata(scrub_wdata),
        .scrub_wecc(scrub_wecc), .scrub_ack(scrub_ack), .scrub_drop(scrub_drop),
        .err_clr(err_clr), .sb_count(sb_count), .db_count(db_count),
        .cap_valid(cap_valid), .cap_type(cap_type), .cap_addr(cap_addr),
        .cap_syndrome(cap_syndrome), .fatal_err(fatal_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ecc_chk_valid  = 1'b0;
        ecc_chk_addr   = '0;
        ecc_single_err = 1'b0;
        ecc_double_err = 1'b0;
        ecc_addr_err   = 1'b0;
        ecc_syndrome   = '0;
        ecc_data_corr  = '0;
        ecc_corr       = '0;
        dccm_wr_valid  = 1'b0;
        dccm_wr_addr   = '0;
        scrub_ack      = 1'b0;
        err_clr        = 1'b0;
    endtask

    task automatic ecc_ev(input logic [AB-1:0] a, input logic s, input logic d, input logic x,
                          input logic [SB-1:0] syn, input logic [DB-1:0] data,
                          input logic [EB-1:0] ecc);
        ecc_chk_valid  = 1'b1;
        ecc_chk_addr   = a;
        ecc_single_err = s;
        ecc_double_err = d;
        ecc_addr_err   = x;
        ecc_syndrome   = syn;
        ecc_data_corr  = data;
        ecc_corr       = ecc;
    endtask

    task automatic push_scrub(input logic [AB-1:0] a, input logic [DB-1:0] d,
                              input logic [EB-1:0] e);
        scrub_t item;
        item.a = a;
        item.d = d;
        item.e = e;
        exp_q.push_back(item);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   scrub_req,    0);
        check({tag, "_saddr"}, scrub_addr,   0);
        check({tag, "_wdata"}, scrub_wdata,  0);
        check({tag, "_wecc"},  scrub_wecc,   0);
        check({tag, "_drop"},  scrub_drop,   0);
        check({tag, "_sb"},    sb_count,     0);
        check({tag, "_db"},    db_count,     0);
        check({tag, "_capv"},  cap_valid,    0);
        check({tag, "_capt"},  cap_type,     0);
        check({tag, "_capa"},  cap_addr,     0);
        check({tag, "_caps"},  cap_syndrome, 0);
        check({tag, "_fatal"}, fatal_err,    0);
    endtask

    // A scrub write is the cycle where req and ack are both high at the next rising edge.
    always @(negedge clk) begin
        if (!rst_a && scrub_req && scrub_ack) begin
            if (exp_q.size() == 0) begin
                check("scrub_unexpected", 1, 0);
            end else begin
                scrub_t e;
                e = exp_q.pop_front();
                check("wr_addr",  scrub_addr,  e.a);
                check("wr_wdata", scrub_wdata, e.d);
                check("wr_wecc",  scrub_wecc,  e.e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_in();
        scrub_enable = 1'b1;
        #12;
        check_all_zero("reset");
        rst_a = 1'b0;
        step();

        // Single error with delayed ack
        ecc_ev(17'h00123, 1, 0, 0, 7'h15, 32'hDEADBEEF, 8'h5A);
        push_scrub(17'h00123, 32'hDEADBEEF, 8'h5A);
        step(); idle_in();
        check("t1_sb", sb_count, 1);
        check("t1_db", db_count, 0);
        check("t1_capv", cap_valid, 1);
        check("t1_capt", cap_type, 2'b01);
        check("t1_capa", cap_addr, 17'h00123);
        check("t1_caps", cap_syndrome, 7'h15);
        check("t1_req", scrub_req, 1);
        check("t1_fatal", fatal_err, 0);
        step(); step();
        check("t1_req_held", scrub_req, 1);
        check("t1_addr_held", scrub_addr, 17'h00123);
        scrub_ack = 1'b1;
        step(); idle_in();
        check("t1_req_after_ack", scrub_req, 0);

        // Store to scrub address cancels, then ack+store in same cycle
        ecc_ev(17'h00123, 1, 0, 0, 7'h03, 32'h11112222, 8'h33);
        step(); idle_in();
        check("t2_req", scrub_req, 1);
        check("t2_sb", sb_count, 2);
        dccm_wr_valid = 1'b1; dccm_wr_addr = 17'h00123;
        step(); idle_in();
        check("t2_cancel", scrub_req, 0);
        step();
        check("t2_stay_idle", scrub_req, 0);
        ecc_ev(17'h00123, 1, 0, 0, 7'h04, 32'h33334444, 8'h44);
        push_scrub(17'h00123, 32'h33334444, 8'h44);
        step(); idle_in();
        check("t2b_req", scrub_req, 1);
        dccm_wr_valid = 1'b1; dccm_wr_addr = 17'h00123; scrub_ack = 1'b1;
        step(); idle_in();
        check("t2b_req_low", scrub_req, 0);
        check("t2b_sb", sb_count, 3);

        // Single then double: capture upgrades, one fatal pulse
        err_clr = 1'b1;
        step(); idle_in();
        check("t3_clr_sb", sb_count, 0);
        check("t3_clr_capv", cap_valid, 0);
        scrub_enable = 1'b0;
        ecc_ev(17'h00010, 1, 0, 0, 7'h21, 32'hCAFE0010, 8'h10);
        step(); idle_in();
        check("t3_sb_en0", sb_count, 1);
        check("t3_capt1", cap_type, 2'b01);
        check("t3_capa1", cap_addr, 17'h00010);
        check("t3_noreq_en0", scrub_req, 0);
        ecc_ev(17'h00020, 0, 1, 0, 7'h7F, 32'hCAFE0020, 8'h20);
        step(); idle_in();
        check("t3_capt2", cap_type, 2'b10);
        check("t3_capa2", cap_addr, 17'h00020);
        check("t3_caps2", cap_syndrome, 7'h7F);
        check("t3_fatal", fatal_err, 1);
        check("t3_db", db_count, 1);
        check("t3_sb", sb_count, 1);
        ecc_ev(17'h00030, 1, 0, 0, 7'h01, 32'h0, 8'h0);
        step(); idle_in();
        check("t3_fatal_pulse", fatal_err, 0);
        check("t3_cap_hold", cap_addr, 17'h00020);
        check("t3_sb2", sb_count, 2);

        // Address error masks simultaneous single
        err_clr = 1'b1;
        step(); idle_in();
        scrub_enable = 1'b1;
        ecc_ev(17'h00033, 1, 0, 1, 7'h0A, 32'h12345678, 8'h9A);
        step(); idle_in();
        check("t4_noreq", scrub_req, 0);
        check("t4_capt", cap_type, 2'b11);
        check("t4_capa", cap_addr, 17'h00033);
        check("t4_fatal", fatal_err, 1);
        check("t4_db", db_count, 1);
        check("t4_sb", sb_count, 0);

        // Singles during REQ set drop; clear + event in one cycle
        err_clr = 1'b1;
        step(); idle_in();
        ecc_ev(17'h00040, 1, 0, 0, 7'h11, 32'hA5A5A5A5, 8'hC3);
        push_scrub(17'h00040, 32'hA5A5A5A5, 8'hC3);
        step(); idle_in();
        check("t5_req", scrub_req, 1);
        check("t5_drop0", scrub_drop, 0);
        ecc_ev(17'h00041, 1, 0, 0, 7'h12, 32'h1, 8'h1);
        step();
        ecc_ev(17'h00042, 1, 0, 0, 7'h13, 32'h2, 8'h2);
        step(); idle_in();
        check("t5_drop", scrub_drop, 1);
        check("t5_sb", sb_count, 3);
        check("t5_addr_held", scrub_addr, 17'h00040);
        scrub_ack = 1'b1;
        step(); idle_in();
        check("t5_req_low", scrub_req, 0);
        err_clr = 1'b1; scrub_enable = 1'b0;
        ecc_ev(17'h00043, 1, 0, 0, 7'h14, 32'h3, 8'h3);
        step(); idle_in();
        check("t5_clr_sb", sb_count, 1);
        check("t5_clr_drop", scrub_drop, 0);
        check("t5_clr_capv", cap_valid, 1);
        check("t5_clr_capa", cap_addr, 17'h00043);

        // Store to the checked word in IDLE suppresses the scrub
        scrub_enable = 1'b1;
        ecc_ev(17'h00050, 1, 0, 0, 7'h05, 32'h5, 8'h5);
        dccm_wr_valid = 1'b1; dccm_wr_addr = 17'h00050;
        step(); idle_in();
        check("t6_noreq", scrub_req, 0);
        check("t6_sb", sb_count, 2);

        // Counter saturation
        err_clr = 1'b1;
        step(); idle_in();
        for (int i = 0; i < 300; i++) begin
            ecc_ev(17'h00060, 0, 1, 0, 7'h60, 32'h60, 8'h60);
            step();
            if (i == 0)   check("t7_db_first", db_count, 1);
            if (i == 253) check("t7_db_254", db_count, 254);
        end
        idle_in();
        check("t7_db_sat", db_count, 255);
        check("t7_sb", sb_count, 0);

        // Enable drop does not abort REQ; async reset does
        ecc_ev(17'h00070, 1, 0, 0, 7'h07, 32'h77777777, 8'h77);
        push_scrub(17'h00070, 32'h77777777, 8'h77);
        step(); idle_in();
        scrub_enable = 1'b0;
        step();
        check("t8_req_en0", scrub_req, 1);
        rst_a = 1'b1;
        #1;
        void'(exp_q.pop_back());
        check_all_zero("t8_async_rst");
        @(negedge clk);
        rst_a = 1'b0;
        step();
        check("t8_after_rst_req", scrub_req, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
